// File: rtl/iter_div_axis.sv
// Radix-2 restoring divider with AXI-stream style operand and result channels.
// One quotient bit per cycle; the result packs {quotient, remainder}.
module iter_div_axis #(
    parameter int SIGNED = 1,
    parameter int WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_axis_divisor_tvalid,
    output logic                 s_axis_divisor_tready,
    input  logic [WIDTH-1:0]     s_axis_divisor_tdata,
    input  logic                 s_axis_dividend_tvalid,
    output logic                 s_axis_dividend_tready,
    input  logic [WIDTH-1:0]     s_axis_dividend_tdata,
    output logic                 m_axis_dout_tvalid,
    input  logic                 m_axis_dout_tready,
    output logic [2*WIDTH-1:0]   m_axis_dout_tdata
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q,    state_d;
    logic             dvs_held_q, dvs_held_d;
    logic             dnd_held_q, dnd_held_d;
    logic [WIDTH-1:0] dvs_raw_q,  dvs_raw_d;
    logic [WIDTH-1:0] dnd_raw_q,  dnd_raw_d;
    logic [WIDTH:0]   dvsr_q,     dvsr_d;
    logic [WIDTH-1:0] rem_q,      rem_d;
    logic [WIDTH-1:0] quo_q,      quo_d;
    logic [CW-1:0]    cnt_q,      cnt_d;
    logic             neg_quo_q,  neg_quo_d;
    logic             neg_rem_q,  neg_rem_d;
    logic             div0_q,     div0_d;

    logic             dvs_fire, dnd_fire;
    logic [WIDTH-1:0] dvs_val,  dnd_val;
    logic             dvs_neg,  dnd_neg;
    logic [WIDTH:0]   dvs_mag;
    logic [WIDTH-1:0] dnd_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   rem_next;
    logic             quo_bit;
    logic [WIDTH-1:0] quo_fix, rem_fix;
    logic             unused_rem_top;

    assign s_axis_divisor_tready  = (state_q == S_IDLE) && !dvs_held_q;
    assign s_axis_dividend_tready = (state_q == S_IDLE) && !dnd_held_q;
    assign dvs_fire = s_axis_divisor_tvalid  && s_axis_divisor_tready;
    assign dnd_fire = s_axis_dividend_tvalid && s_axis_dividend_tready;

    // Operand values as seen at this edge: the incoming beat wins over the held copy.
    assign dvs_val = dvs_fire ? s_axis_divisor_tdata  : dvs_raw_q;
    assign dnd_val = dnd_fire ? s_axis_dividend_tdata : dnd_raw_q;
    assign dvs_neg = (SIGNED != 0) && dvs_val[WIDTH-1];
    assign dnd_neg = (SIGNED != 0) && dnd_val[WIDTH-1];

    // Divisor magnitude needs WIDTH+1 bits so the most negative value maps to 2^(WIDTH-1) cleanly.
    assign dvs_mag = dvs_neg ? -{1'b1, dvs_val} : {1'b0, dvs_val};
    assign dnd_mag = dnd_neg ? -dnd_val : dnd_val;

    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign quo_bit  = (shifted >= dvsr_q);
    assign rem_next = quo_bit ? (shifted - dvsr_q) : shifted;
    assign unused_rem_top = rem_next[WIDTH];

    // Divide by zero keeps the all-ones quotient unnegated; the remainder fix-up restores the dividend.
    assign quo_fix = (neg_quo_q && !div0_q) ? -quo_q : quo_q;
    assign rem_fix = neg_rem_q ? -rem_q : rem_q;

    assign m_axis_dout_tvalid = (state_q == S_DONE);
    assign m_axis_dout_tdata  = (state_q == S_DONE) ? {quo_fix, rem_fix} : '0;

    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    always_comb begin
        state_d    = state_q;
        dvs_held_d = dvs_held_q;
        dnd_held_d = dnd_held_q;
        dvs_raw_d  = dvs_raw_q;
        dnd_raw_d  = dnd_raw_q;
        dvsr_d     = dvsr_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        div0_d     = div0_q;

        case (state_q)
            S_IDLE: begin
                if (dvs_fire) begin
                    dvs_held_d = 1'b1;
                    dvs_raw_d  = s_axis_divisor_tdata;
                end
                if (dnd_fire) begin
                    dnd_held_d = 1'b1;
                    dnd_raw_d  = s_axis_dividend_tdata;
                end
                if ((dvs_held_q || dvs_fire) && (dnd_held_q || dnd_fire)) begin
                    state_d   = S_CALC;
                    cnt_d     = '0;
                    dvsr_d    = dvs_mag;
                    quo_d     = dnd_mag;
                    rem_d     = '0;
                    neg_quo_d = dvs_neg ^ dnd_neg;
                    neg_rem_d = dnd_neg;
                    div0_d    = (dvs_val == '0);
                end
            end
            S_CALC: begin
                rem_d = rem_next[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], quo_bit};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (m_axis_dout_tready) begin
                    state_d    = S_IDLE;
                    dvs_held_d = 1'b0;
                    dnd_held_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            dvs_held_q <= 1'b0;
            dnd_held_q <= 1'b0;
            dvs_raw_q  <= '0;
            dnd_raw_q  <= '0;
            dvsr_q     <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div0_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dvs_held_q <= dvs_held_d;
            dnd_held_q <= dnd_held_d;
            dvs_raw_q  <= dvs_raw_d;
            dnd_raw_q  <= dnd_raw_d;
            dvsr_q     <= dvsr_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            div0_q     <= div0_d;
        end
    end

endmodule

// File: tb/tb_iter_div_axis.sv
// Bench for iter_div_axis: unsigned (index 0) and signed (index 1) instances,
// directed cases then randomized operations checked against an arithmetic model.
module tb_iter_div_axis;

    localparam int WIDTH = 32;
    localparam int N_RAND = 1200;

    logic        clk;
    logic        rst;
    logic        dvs_valid [2];
    logic        dvs_ready [2];
    logic [31:0] dvs_data  [2];
    logic        dnd_valid [2];
    logic        dnd_ready [2];
    logic [31:0] dnd_data  [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [63:0] out_data  [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    iter_div_axis #(.SIGNED(0), .WIDTH(WIDTH)) u_div_u (
        .clk(clk), .rst(rst),
        .s_axis_divisor_tvalid(dvs_valid[0]), .s_axis_divisor_tready(dvs_ready[0]),
        .s_axis_divisor_tdata(dvs_data[0]),
        .s_axis_dividend_tvalid(dnd_valid[0]), .s_axis_dividend_tready(dnd_ready[0]),
        .s_axis_dividend_tdata(dnd_data[0]),
        .m_axis_dout_tvalid(out_valid[0]), .m_axis_dout_tready(out_ready[0]),
        .m_axis_dout_tdata(out_data[0])
    );

    iter_div_axis #(.SIGNED(1), .WIDTH(WIDTH)) u_div_s (
        .clk(clk), .rst(rst),
        .s_axis_divisor_tvalid(dvs_valid[1]), .s_axis_divisor_tready(dvs_ready[1]),
        .s_axis_divisor_tdata(dvs_data[1]),
        .s_axis_dividend_tvalid(dnd_valid[1]), .s_axis_dividend_tready(dnd_ready[1]),
        .s_axis_dividend_tdata(dnd_data[1]),
        .m_axis_dout_tvalid(out_valid[1]), .m_axis_dout_tready(out_ready[1]),
        .m_axis_dout_tdata(out_data[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Quotient truncates toward zero, remainder takes the dividend's sign; x/0 gives all ones and x.
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] n, input logic [31:0] d);
        longint a, b, qq, rr;
        logic [31:0] q, r;
        if (d == 32'd0) return {32'hFFFF_FFFF, n};
        if (sgn) begin
            a  = longint'($signed(n));
            b  = longint'($signed(d));
            qq = a / b;
            rr = a % b;
            q  = 32'(qq);
            r  = 32'(rr);
        end else begin
            q = n / d;
            r = n % d;
        end
        return {q, r};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 15));
            5:       return -32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic send(input int i, input string tag, input logic [31:0] n, input logic [31:0] d,
                        input int lag_s, input int lag_d, output int hs);
        int c;
        bit got_s, got_d, rs, rd;
        c = 0; got_s = 0; got_d = 0;
        while (!(got_s && got_d) && c < 200) begin
            if (!got_s && c >= lag_s) begin dvs_valid[i] = 1'b1; dvs_data[i] = d; end
            if (!got_d && c >= lag_d) begin dnd_valid[i] = 1'b1; dnd_data[i] = n; end
            if (got_s && !got_d) check({tag, "_dvs_rdy_held"}, 64'(dvs_ready[i]), 64'd0);
            if (got_d && !got_s) check({tag, "_dnd_rdy_held"}, 64'(dnd_ready[i]), 64'd0);
            rs = dvs_ready[i];
            rd = dnd_ready[i];
            @(posedge clk); #1; c++;
            if (dvs_valid[i] && rs) begin got_s = 1; dvs_valid[i] = 1'b0; end
            if (dnd_valid[i] && rd) begin got_d = 1; dnd_valid[i] = 1'b0; end
        end
        hs = cyc;
        if (!(got_s && got_d)) begin
            check({tag, "_send_timeout"}, 64'd0, 64'd1);
            dvs_valid[i] = 1'b0;
            dnd_valid[i] = 1'b0;
        end
    endtask

    task automatic recv(input int i, input string tag, input int hold,
                        output logic [63:0] data, output int v_edge);
        int c;
        c = 0;
        out_ready[i] = 1'b0;
        while (!out_valid[i] && c < 200) begin
            @(posedge clk); #1; c++;
        end
        if (!out_valid[i]) begin
            check({tag, "_recv_timeout"}, 64'd0, 64'd1);
            data = '0;
            v_edge = -1;
            return;
        end
        v_edge = cyc;
        data   = out_data[i];
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, "_hold_data"}, out_data[i], data);
            check({tag, "_hold_valid"}, 64'(out_valid[i]), 64'd1);
            check({tag, "_hold_rdys"}, 64'({dvs_ready[i], dnd_ready[i]}), 64'd0);
        end
        out_ready[i] = 1'b1;
        @(posedge clk); #1;
        out_ready[i] = 1'b0;
        check({tag, "_post_valid"}, 64'(out_valid[i]), 64'd0);
        check({tag, "_post_data"}, out_data[i], 64'd0);
        check({tag, "_post_rdys"}, 64'({dvs_ready[i], dnd_ready[i]}), 64'd3);
    endtask

    task automatic do_op(input int i, input string tag, input logic [31:0] n, input logic [31:0] d,
                         input int lag_s, input int lag_d, input int hold,
                         input logic [63:0] exp, output int v_edge);
        int hs;
        logic [63:0] got;
        send(i, tag, n, d, lag_s, lag_d, hs);
        recv(i, tag, hold, got, v_edge);
        check({tag, "_data"}, got, exp);
        check({tag, "_latency"}, 64'(v_edge - hs), 64'(WIDTH));
    endtask

    task automatic rand_run(input int i);
        logic [31:0] n, d;
        int ve;
        for (int k = 0; k < N_RAND; k++) begin
            n = pick();
            d = pick();
            do_op(i, $sformatf("rand%0d_%0d", i, k), n, d, $urandom_range(0, 2),
                  $urandom_range(0, 2), $urandom_range(0, 1), ref_div(i == 1, n, d), ve);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ve, ve2, hs;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            dvs_valid[i] = 1'b0; dnd_valid[i] = 1'b0; out_ready[i] = 1'b0;
            dvs_data[i] = '0; dnd_data[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset%0d_valid", i), 64'(out_valid[i]), 64'd0);
            check($sformatf("reset%0d_data", i), out_data[i], 64'd0);
            check($sformatf("reset%0d_rdys", i), 64'({dvs_ready[i], dnd_ready[i]}), 64'd3);
        end

        do_op(0, "u_100_7",    32'd100,        32'd7,          0, 0, 0, 64'h0000000E_00000002, ve);
        do_op(1, "s_m7_2",     -32'sd7,        32'd2,          0, 0, 0, 64'hFFFFFFFD_FFFFFFFF, ve);
        do_op(1, "s_7_m2",     32'd7,          -32'sd2,        0, 0, 0, 64'hFFFFFFFD_00000001, ve);
        do_op(1, "s_ovf",      32'h8000_0000,  32'hFFFF_FFFF,  0, 0, 0, 64'h80000000_00000000, ve);
        do_op(1, "s_div0",     -32'sd5,        32'd0,          0, 0, 0, 64'hFFFFFFFF_FFFFFFFB, ve);
        do_op(0, "u_max_1",    32'hFFFF_FFFF,  32'd1,          0, 0, 0, 64'hFFFFFFFF_00000000, ve);
        do_op(0, "u_div0",     32'h0000_1234,  32'd0,          1, 0, 0, 64'hFFFFFFFF_00001234, ve);
        do_op(0, "u_stagger",  32'd9,          32'd3,          0, 4, 6, 64'h00000003_00000000, ve);

        // Abort an operation part-way through the iterations.
        send(0, "u_abort", 32'd50, 32'd3, 0, 0, hs);
        repeat (10) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_valid", 64'(out_valid[0]), 64'd0);
        check("abort_data", out_data[0], 64'd0);
        check("abort_rdys", 64'({dvs_ready[0], dnd_ready[0]}), 64'd3);
        do_op(0, "u_after_abort", 32'd9, 32'd3, 0, 0, 0, 64'h00000003_00000000, ve);

        // Two operations at the earliest legal issue points: results WIDTH+2 edges apart.
        do_op(0, "u_b2b_a", 32'd1000, 32'd10, 0, 0, 0, 64'h00000064_00000000, ve);
        do_op(0, "u_b2b_b", 32'd1001, 32'd10, 0, 0, 0, 64'h00000064_00000001, ve2);
        check("b2b_interval", 64'(ve2 - ve), 64'(WIDTH + 2));

        fork
            rand_run(0);
            rand_run(1);
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
